// File: rtl/cardinal_pipe_core.sv
// cardinal_pipe_core: four-stage (IF, ID, EX/MEM, WB) 64-bit lane-parallel core.
// Big-endian ports: bit 0 is the MSB, so internal [N-1:0] vectors map directly.

module cardinal_pipe_rf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [63:0] i_wd,
  input  logic [4:0]  i_ra_a,
  input  logic [4:0]  i_ra_b,
  input  logic [4:0]  i_ra_d,
  output logic [63:0] o_rd_a,
  output logic [63:0] o_rd_b,
  output logic [63:0] o_rd_d
);
  logic [63:0] data_arr [32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) data_arr[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      data_arr[i_wa] <= i_wd;
    end
  end

  // Write-through so ID sees the value WB is committing this cycle.
  assign o_rd_a = (i_ra_a == 5'd0) ? '0 : (i_we && i_wa == i_ra_a) ? i_wd : data_arr[i_ra_a];
  assign o_rd_b = (i_ra_b == 5'd0) ? '0 : (i_we && i_wa == i_ra_b) ? i_wd : data_arr[i_ra_b];
  assign o_rd_d = (i_ra_d == 5'd0) ? '0 : (i_we && i_wa == i_ra_d) ? i_wd : data_arr[i_ra_d];
endmodule

module cardinal_pipe_core (
  input  logic        Clock,
  input  logic        Reset,
  output logic [0:7]  Instr_Addr,
  input  logic [0:31] Instruction,
  output logic [0:7]  Mem_Addr,
  output logic [0:63] Data_Out,
  input  logic [0:63] Data_In,
  output logic        DmemEn,
  output logic        DmemWrEn
);
  typedef enum logic [1:0] {K_NOP, K_ALU, K_LD, K_ST} kind_e;

  localparam logic [5:0] OP_ALU   = 6'b101010;
  localparam logic [5:0] OP_VLD   = 6'b100000;
  localparam logic [5:0] OP_VSD   = 6'b100001;
  localparam logic [5:0] OP_VBEZ  = 6'b100010;
  localparam logic [5:0] OP_VBNEZ = 6'b100011;

  function automatic logic f_func_ok(input logic [5:0] func);
    case (func)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd10, 6'd11, 6'd12: f_func_ok = 1'b1;
      default: f_func_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] f_mask(input logic [2:0] ppp);
    case (ppp)
      3'd0:    f_mask = '1;
      3'd1:    f_mask = 64'hFFFF_FFFF_0000_0000;
      3'd2:    f_mask = 64'h0000_0000_FFFF_FFFF;
      3'd3:    f_mask = 64'hFF00_FF00_FF00_FF00;
      3'd4:    f_mask = 64'h00FF_00FF_00FF_00FF;
      default: f_mask = '0;
    endcase
  endfunction

  // Lane-wise add/sub/shift; lanes are isolated by masking before and after.
  function automatic logic [63:0] f_lane(input logic [5:0] func, input logic [1:0] ww,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r, lmask, la, lb, lx, lr;
    logic [5:0]  sh;
    int          lw, nl;
    lw = 8 << ww;
    nl = 8 >> ww;
    lmask = (ww == 2'd3) ? '1 : ((64'd1 << lw) - 64'd1);
    r = '0;
    for (int l = 0; l < 8; l++) begin
      la = '0; lb = '0; lx = '0; lr = '0; sh = '0;
      if (l < nl) begin
        la = (a >> (l * lw)) & lmask;
        lb = (b >> (l * lw)) & lmask;
        sh = lb[5:0] & 6'(lw - 1);
        lx = la | (la[6'(lw - 1)] ? ~lmask : '0);
        case (func)
          6'd6:    lr = la + lb;
          6'd7:    lr = la - lb;
          6'd10:   lr = la << sh;
          6'd11:   lr = la >> sh;
          default: lr = $signed(lx) >>> sh;
        endcase
        r = r | ((lr & lmask) << (l * lw));
      end
    end
    f_lane = r;
  endfunction

  function automatic logic [63:0] f_alu(input logic [5:0] func, input logic [1:0] ww,
                                        input logic [63:0] a, input logic [63:0] b);
    case (func)
      6'd1:    f_alu = a & b;
      6'd2:    f_alu = a | b;
      6'd3:    f_alu = a ^ b;
      6'd4:    f_alu = ~a;
      6'd5:    f_alu = a;
      default: f_alu = f_lane(func, ww, a, b);
    endcase
  endfunction

  logic [7:0]  r_pc_p0;
  logic [31:0] r_instr_p1;
  kind_e       r_kind_p2;
  logic        r_vld_p2, r_vld_p3;
  logic [4:0]  r_rd_p2, r_ra_p2, r_rb_p2, r_rd_p3;
  logic [1:0]  r_ww_p2;
  logic [5:0]  r_func_p2;
  logic [7:0]  r_addr_p2;
  logic [63:0] r_mask_p2;
  logic [63:0] r_a_p2, r_b_p2, r_d_p2, r_res_p3;

  logic [31:0] w_instr;
  logic [63:0] w_din, w_a_p1, w_b_p1, w_d_p1;
  logic [5:0]  w_op;
  logic [4:0]  w_rd, w_ra, w_rb;
  kind_e       w_kind_p1;
  logic        w_wr_p1, w_is_br, w_stall, w_taken;
  logic [63:0] w_fa, w_fb, w_fd, w_res_p2;

  assign w_instr = Instruction;
  assign w_din   = Data_In;

  // ---- IF / ID boundary: decode, register read, branch resolution ----
  assign w_op = r_instr_p1[31:26];
  assign w_rd = r_instr_p1[25:21];
  assign w_ra = r_instr_p1[20:16];
  assign w_rb = r_instr_p1[15:11];

  cardinal_pipe_rf rf (
    .i_clk  (Clock),
    .i_rst_n(Reset),
    .i_we   (r_vld_p3),
    .i_wa   (r_rd_p3),
    .i_wd   (r_res_p3),
    .i_ra_a (w_ra),
    .i_ra_b (w_rb),
    .i_ra_d (w_rd),
    .o_rd_a (w_a_p1),
    .o_rd_b (w_b_p1),
    .o_rd_d (w_d_p1)
  );

  always_comb begin
    w_kind_p1 = K_NOP;
    case (w_op)
      OP_ALU:  w_kind_p1 = K_ALU;
      OP_VLD:  w_kind_p1 = K_LD;
      OP_VSD:  w_kind_p1 = K_ST;
      default: w_kind_p1 = K_NOP;
    endcase
  end

  assign w_wr_p1 = (w_rd != 5'd0) &&
                   ((w_kind_p1 == K_LD) ||
                    (w_kind_p1 == K_ALU && f_func_ok(r_instr_p1[5:0]) && r_instr_p1[10:8] <= 3'd4));
  assign w_is_br = (w_op == OP_VBEZ) || (w_op == OP_VBNEZ);
  assign w_stall = w_is_br && r_vld_p2 && (r_rd_p2 == w_rd);
  assign w_taken = w_is_br && !w_stall && ((w_op == OP_VBEZ) ? (w_d_p1 == '0) : (w_d_p1 != '0));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pc_p0    <= '0;
      r_instr_p1 <= '0;
      r_kind_p2  <= K_NOP;
      r_vld_p2   <= 1'b0;
      r_rd_p2    <= '0;
      r_ra_p2    <= '0;
      r_rb_p2    <= '0;
      r_ww_p2    <= '0;
      r_func_p2  <= '0;
      r_addr_p2  <= '0;
      r_mask_p2  <= '0;
      r_vld_p3   <= 1'b0;
      r_rd_p3    <= '0;
    end else begin
      r_rd_p2   <= w_rd;
      r_ra_p2   <= w_ra;
      r_rb_p2   <= w_rb;
      r_ww_p2   <= r_instr_p1[7:6];
      r_func_p2 <= r_instr_p1[5:0];
      r_addr_p2 <= r_instr_p1[7:0];
      r_mask_p2 <= (w_kind_p1 == K_LD) ? '1 : f_mask(r_instr_p1[10:8]);
      if (w_stall) begin
        r_kind_p2 <= K_NOP;
        r_vld_p2  <= 1'b0;
      end else begin
        r_kind_p2 <= w_kind_p1;
        r_vld_p2  <= w_wr_p1;
        if (w_taken) begin
          r_pc_p0    <= r_instr_p1[7:0];
          r_instr_p1 <= '0;
        end else begin
          r_pc_p0    <= r_pc_p0 + 8'd1;
          r_instr_p1 <= w_instr;
        end
      end
      r_vld_p3 <= r_vld_p2;
      r_rd_p3  <= r_rd_p2;
    end
  end

  always_ff @(posedge Clock) begin
    r_a_p2   <= w_a_p1;
    r_b_p2   <= w_b_p1;
    r_d_p2   <= w_d_p1;
    r_res_p3 <= w_res_p2;
  end

  // ---- ID / EX boundary: forwarding from WB, ALU, byte-mask merge ----
  assign w_fa = (r_vld_p3 && r_rd_p3 == r_ra_p2) ? r_res_p3 : r_a_p2;
  assign w_fb = (r_vld_p3 && r_rd_p3 == r_rb_p2) ? r_res_p3 : r_b_p2;
  assign w_fd = (r_vld_p3 && r_rd_p3 == r_rd_p2) ? r_res_p3 : r_d_p2;

  assign w_res_p2 = (r_kind_p2 == K_LD) ? w_din
                  : (f_alu(r_func_p2, r_ww_p2, w_fa, w_fb) & r_mask_p2) | (w_fd & ~r_mask_p2);

  assign Instr_Addr = r_pc_p0;
  assign DmemEn     = (r_kind_p2 == K_LD) || (r_kind_p2 == K_ST);
  assign DmemWrEn   = (r_kind_p2 == K_ST);
  assign Mem_Addr   = DmemEn ? r_addr_p2 : '0;
  assign Data_Out   = DmemWrEn ? w_fd : '0;
endmodule

// File: tb/tb_cardinal_pipe_core.sv
// Scoreboard bench for cardinal_pipe_core: bench-side memories, expected stores
// queued per program, and a monitor that checks every store the core issues.

module tb_cardinal_pipe_core;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [0:7]  Instr_Addr, Mem_Addr;
  logic [0:31] Instruction;
  logic [0:63] Data_Out, Data_In;
  logic        DmemEn, DmemWrEn;

  logic [31:0] imem [256];
  logic [63:0] dmem [256];

  localparam logic [5:0] VLD = 6'b100000, VSD = 6'b100001, VBEZ = 6'b100010, VBNEZ = 6'b100011;
  localparam logic [5:0] F_XOR = 6'd3, F_MOV = 6'd5, F_ADD = 6'd6, F_SUB = 6'd7;
  localparam logic [5:0] F_SLL = 6'd10, F_SRL = 6'd11, F_SRA = 6'd12;

  typedef struct { logic [7:0] addr; logic [63:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_tot  = 0;

  cardinal_pipe_core dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Instr_Addr (Instr_Addr),
    .Instruction(Instruction),
    .Mem_Addr   (Mem_Addr),
    .Data_Out   (Data_Out),
    .Data_In    (Data_In),
    .DmemEn     (DmemEn),
    .DmemWrEn   (DmemWrEn)
  );

  always #5 Clock = ~Clock;

  assign Instruction = imem[Instr_Addr];
  assign Data_In     = dmem[Mem_Addr];
  always @(posedge Clock) if (DmemEn && DmemWrEn) dmem[Mem_Addr] <= Data_Out;

  function automatic logic [31:0] r_op(input logic [5:0] func, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [2:0] ppp, input logic [1:0] ww);
    return {6'b101010, rd, ra, rb, ppp, ww, func};
  endfunction

  function automatic logic [31:0] m_op(input logic [5:0] op, input logic [4:0] rd, input logic [7:0] addr);
    return {op, rd, 5'd0, 8'd0, addr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic expect_store(input logic [7:0] addr, input logic [63:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b1 && DmemEn && DmemWrEn) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected store: addr %0d data %h, no store required", Mem_Addr, Data_Out);
      end else begin
        mon_e = exp_q.pop_front();
        check("store addr", 64'(Mem_Addr), 64'(mon_e.addr));
        check("store data", Data_Out, mon_e.data);
      end
    end
  end

  task automatic begin_test();
    Reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      imem[8'(i)] = '0;
      dmem[8'(i)] = '0;
    end
  endtask

  task automatic hold_reset();
    int nz;
    repeat (5) @(negedge Clock);
    check("reset Instr_Addr", 64'(Instr_Addr), 64'd0);
    check("reset DmemEn/WrEn", 64'({DmemEn, DmemWrEn}), 64'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf.data_arr[5'(i)] !== 64'd0) nz++;
    check("reset rf nonzero entries", 64'(nz), 64'd0);
    Reset = 1'b1;
  endtask

  task automatic finish_prog(input int cycles);
    repeat (cycles) @(negedge Clock);
    check("pending stores", 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] pc_trace [6] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd10, 8'd11};

  initial begin
    // Instruction flow and PC wrap
    begin_test();
    hold_reset();
    for (int k = 0; k < 4; k++) begin
      check("pc step", 64'(Instr_Addr), 64'(k));
      @(negedge Clock);
    end
    repeat (252) @(negedge Clock);
    check("pc wrap", 64'(Instr_Addr), 64'd0);

    // Load/add/store with forwarding, lane widths
    begin_test();
    dmem[0] = 64'h01FF_0203_0405_0607;
    dmem[1] = 64'h0101_0101_0101_0101;
    imem[0] = m_op(VLD, 5'd1, 8'd0);
    imem[1] = m_op(VLD, 5'd2, 8'd1);
    imem[2] = r_op(F_ADD, 5'd3, 5'd1, 5'd2, 3'd0, 2'd0);
    imem[3] = m_op(VSD, 5'd3, 8'd2);
    imem[4] = r_op(F_SUB, 5'd4, 5'd1, 5'd2, 3'd0, 2'd1);
    imem[5] = m_op(VSD, 5'd4, 8'd3);
    imem[6] = r_op(F_XOR, 5'd5, 5'd1, 5'd2, 3'd0, 2'd0);
    imem[7] = m_op(VSD, 5'd5, 8'd4);
    imem[8] = r_op(F_ADD, 5'd6, 5'd1, 5'd2, 3'd0, 2'd3);
    imem[9] = m_op(VSD, 5'd6, 8'd5);
    expect_store(8'd2, 64'h0200_0304_0506_0708);
    expect_store(8'd3, 64'h00FE_0102_0304_0506);
    expect_store(8'd4, 64'h00FE_0302_0504_0706);
    expect_store(8'd5, 64'h0300_0304_0506_0708);
    hold_reset();
    finish_prog(40);
    check("mem[2] after store", dmem[2], 64'h0200_0304_0506_0708);

    // PPP byte masks
    begin_test();
    dmem[0] = '1;
    imem[0] = m_op(VLD, 5'd1, 8'd0);
    imem[1] = r_op(F_MOV, 5'd3, 5'd1, 5'd0, 3'd3, 2'd0);
    imem[2] = m_op(VSD, 5'd3, 8'd10);
    imem[3] = r_op(F_MOV, 5'd4, 5'd1, 5'd0, 3'd1, 2'd0);
    imem[4] = m_op(VSD, 5'd4, 8'd11);
    imem[5] = r_op(F_MOV, 5'd3, 5'd1, 5'd0, 3'd2, 2'd0);
    imem[6] = m_op(VSD, 5'd3, 8'd12);
    imem[7] = r_op(F_MOV, 5'd5, 5'd1, 5'd0, 3'd5, 2'd0);
    imem[8] = m_op(VSD, 5'd5, 8'd13);
    expect_store(8'd10, 64'hFF00_FF00_FF00_FF00);
    expect_store(8'd11, 64'hFFFF_FFFF_0000_0000);
    expect_store(8'd12, 64'hFF00_FF00_FFFF_FFFF);
    expect_store(8'd13, 64'h0000_0000_0000_0000);
    hold_reset();
    finish_prog(40);

    // Per-lane shifts
    begin_test();
    dmem[0] = 64'h8000_0000_8000_0000;
    dmem[1] = 64'h0000_0001_0000_0001;
    imem[0] = m_op(VLD, 5'd1, 8'd0);
    imem[1] = m_op(VLD, 5'd2, 8'd1);
    imem[2] = r_op(F_SRA, 5'd3, 5'd1, 5'd2, 3'd0, 2'd2);
    imem[3] = m_op(VSD, 5'd3, 8'd10);
    imem[4] = r_op(F_SRL, 5'd4, 5'd1, 5'd2, 3'd0, 2'd2);
    imem[5] = m_op(VSD, 5'd4, 8'd11);
    imem[6] = r_op(F_SLL, 5'd5, 5'd2, 5'd2, 3'd0, 2'd0);
    imem[7] = m_op(VSD, 5'd5, 8'd12);
    imem[8] = r_op(F_SLL, 5'd6, 5'd1, 5'd2, 3'd0, 2'd2);
    imem[9] = m_op(VSD, 5'd6, 8'd13);
    expect_store(8'd10, 64'hC000_0000_C000_0000);
    expect_store(8'd11, 64'h4000_0000_4000_0000);
    expect_store(8'd12, 64'h0000_0002_0000_0002);
    expect_store(8'd13, 64'h0000_0000_0000_0000);
    hold_reset();
    finish_prog(40);

    // Branches: stall, taken with flush, not taken
    begin_test();
    dmem[6]  = 64'h1234_5678_9ABC_DEF0;
    imem[0]  = m_op(VLD, 5'd1, 8'd5);
    imem[1]  = m_op(VBEZ, 5'd1, 8'd10);
    imem[2]  = m_op(VSD, 5'd1, 8'd20);
    imem[10] = m_op(VBNEZ, 5'd0, 8'd20);
    imem[11] = m_op(VLD, 5'd2, 8'd6);
    imem[12] = m_op(VSD, 5'd2, 8'd31);
    imem[13] = m_op(VBNEZ, 5'd2, 8'd40);
    imem[14] = m_op(VSD, 5'd2, 8'd32);
    imem[40] = m_op(VSD, 5'd2, 8'd33);
    expect_store(8'd31, 64'h1234_5678_9ABC_DEF0);
    expect_store(8'd33, 64'h1234_5678_9ABC_DEF0);
    hold_reset();
    for (int k = 0; k < 6; k++) begin
      check("branch pc trace", 64'(Instr_Addr), 64'(pc_trace[k]));
      @(negedge Clock);
    end
    finish_prog(60);
    check("flushed store mem[20]", dmem[20], 64'd0);

    // Register zero
    begin_test();
    dmem[0] = 64'd5;
    imem[0] = m_op(VLD, 5'd1, 8'd0);
    imem[1] = r_op(F_ADD, 5'd0, 5'd1, 5'd1, 3'd0, 2'd3);
    imem[2] = r_op(F_ADD, 5'd2, 5'd0, 5'd1, 3'd0, 2'd3);
    imem[3] = m_op(VSD, 5'd2, 8'd7);
    imem[4] = m_op(VSD, 5'd0, 8'd8);
    expect_store(8'd7, 64'd5);
    expect_store(8'd8, 64'd0);
    hold_reset();
    finish_prog(30);
    check("rf R0", dut.rf.data_arr[0], 64'd0);

    // Async reset during a store aborts it
    begin_test();
    dmem[0] = 64'hDEAD_BEEF_0BAD_F00D;
    imem[0] = m_op(VLD, 5'd1, 8'd0);
    imem[1] = m_op(VSD, 5'd1, 8'd50);
    imem[2] = m_op(VSD, 5'd1, 8'd51);
    expect_store(8'd50, 64'hDEAD_BEEF_0BAD_F00D);
    hold_reset();
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    check("mid-reset DmemEn/WrEn", 64'({DmemEn, DmemWrEn}), 64'd0);
    check("mid-reset Mem_Addr/Data_Out", {56'd0, Mem_Addr} | Data_Out, 64'd0);
    repeat (3) @(negedge Clock);
    check("pending stores", 64'(exp_q.size()), 64'd0);
    check("aborted store mem[51]", dmem[51], 64'd0);
    check("completed store mem[50]", dmem[50], 64'hDEAD_BEEF_0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cardinal_pipe_core.md
Name: cardinal_pipe_core

Overview:
- 64-bit, variable-lane-width (byte/half/word/double) four-stage pipelined processor core: IF, ID, EX/MEM, WB.
- Drives a word-addressed 256x32 instruction memory and a 256x64 data memory. Both memories sit outside the core.
- Contains a 32x64 register file, instance name rf, array data_arr, with R0 hardwired to zero.
- Bit numbering is big-endian: bit 0 is the MSB; byte 0 is bits [0:7].

Parameters:
- none (widths fixed: data 64, instruction 32, addresses 8, registers 32)

Ports:
- Clock  in  1  system clock, rising-edge active
- Reset  in  1  reset; one clock; reset is asynchronous and active-low
- Instr_Addr  out  [0:7]  PC to imem; word address
- Instruction  in  [0:31]  combinational imem read data for Instr_Addr
- Mem_Addr  out  [0:7]  dmem address
- Data_Out  out  [0:63]  store data to dmem
- Data_In  in  [0:63]  combinational dmem read data
- DmemEn  out  1  dmem access enable
- DmemWrEn  out  1  dmem write enable; write is captured by dmem at the Clock rising edge

Behaviour:
- Reset (Reset=0, async), all held while asserted:
  - PC=0
  - all pipeline registers set to NOP
  - all rf entries = 0
  - DmemEn=0, DmemWrEn=0
  - Data_Out=0, Mem_Addr=0
- Instruction fields:
  - opcode [0:5], rD [6:10], rA [11:15], rB [16:20]
  - PPP [21:23], WW [24:25], func [26:31]
  - immediate [16:31]; only [24:31] is used as an address
- Opcodes:
  - 101010 = R-type ALU
  - 100000 = VLD: rD <= MEM[imm]
  - 100001 = VSD: MEM[imm] <= rD
  - 100010 = VBEZ: branch to imm if rD == 0
  - 100011 = VBNEZ: branch to imm if rD != 0
  - 111100 = VNOP
  - 32'h00000000 and every other opcode execute as NOP: no register write, no memory access.
- R-type func codes:
  - 000001 AND, 000010 OR, 000011 XOR
  - 000100 NOT (of rA), 000101 MOV (rA)
  - 000110 ADD, 000111 SUB
  - 001010 SLL, 001011 SRL, 001100 SRA
  - Undefined func codes: no register write.
- Lane width WW: 00 = 8 lanes of 8 bits, 01 = 16-bit lanes, 10 = 32-bit lanes, 11 = one 64-bit lane.
  - ADD/SUB: modulo per lane, no carry or borrow across lanes.
  - Shifts: per lane, shift amount = low log2(lane width) bits of the corresponding rB lane (3/4/5/6 bits).
  - SRA: sign-fills from the lane MSB.
  - Logical ops ignore WW.
- PPP write-back byte mask (R-type only):
  - 000 = all bytes
  - 001 = bytes 0-3
  - 010 = bytes 4-7
  - 011 = even bytes
  - 100 = odd bytes
  - 101-111 = no write
  - Unmasked bytes keep their old rD value.
- VLD writes all 64 bits. Any write to R0 is discarded.
- Pipeline timing:
  - IF: Instr_Addr=PC; PC <= PC+1, wrapping 255 -> 0.
  - ID: register read. The rf is write-through, so a WB write in the same cycle is visible.
  - EX/MEM: ALU result, or memory access.
    - VLD: DmemEn=1, DmemWrEn=0, Mem_Addr=imm[24:31]; Data_In is latched at the end of the cycle.
    - VSD: DmemEn=1, DmemWrEn=1, Data_Out=rD.
    - Otherwise DmemEn=0, DmemWrEn=0.
  - WB: rf written at the rising edge.
- Forwarding: rA, rB and store-data rD operands in EX take the WB result when the WB register matches and is nonzero. No load-use stall is needed.
- Branches: resolved in ID.
  - If the instruction in EX writes the branch's rD, stall one cycle: PC and IF/ID hold, a NOP is injected into EX.
  - Taken branch: PC <= imm[24:31]; the instruction in IF is flushed to a NOP. One bubble.
- Simultaneous events:
  - A stall and a taken branch cannot coincide; the stall resolves first.
  - An async reset mid-program aborts all in-flight instructions; no memory write occurs while Reset=0.

Test Plan:
1. Reset and instruction flow:
   - Reset low for 5 cycles -> Instr_Addr=0, DmemEn=0, all rf = 0.
   - After release, Instr_Addr increments by 1 each cycle.
2. Load / add / store with forwarding:
   - Program: VLD R1,0; VLD R2,1; ADD R3,R1,R2 (WW=00, PPP=000); VSD R3,2; then 0x00000000.
   - Inputs: MEM[0]=0x01FF_0203_0405_0607, MEM[1]=0x0101_0101_0101_0101.
   - Expect MEM[2]=0x0200_0304_0506_0708, with no byte carry and back-to-back forwarding.
3. PPP masking:
   - R1=0xFFFF..FF, R3=0 preset; MOV R3,R1 with PPP=011 -> R3=0xFF00FF00FF00FF00.
   - With PPP=001 -> 0xFFFFFFFF00000000.
4. Shifts:
   - R1=0x8000_0000_8000_0000, R2 low bits 1; SRA with WW=10 -> R3=0xC000_0000_C000_0000.
   - Same operands with SRL -> 0x4000_0000_4000_0000.
5. Branches:
   - Sequence: VLD R1 (value 0); VBEZ R1 to address 10. Expect a one-cycle stall, then the branch is taken and the instruction at PC+1 does not write.
   - VBNEZ on R0 is not taken.
6. Register zero:
   - ADD R0,R1,R1 with R1=5 -> R0 reads 0, and a dependent instruction sees 0.
